// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter between the CPU and the VGA pixel fetcher.
// A CPU_OWN -> DRAIN -> VGA_OWN owner FSM with bounded-starvation sharing and tagged read returns.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_done,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              restart,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    CPU_OWN = 2'b00,
    DRAIN   = 2'b01,
    VGA_OWN = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'b00,
    TAG_CPU  = 2'b01,
    TAG_VGA  = 2'b10
  } tag_t;

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  state_t           state, state_nxt;
  tag_t             tag, tag_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             cpu_gnt, vga_gnt;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    cpu_gnt      = 1'b0;
    vga_gnt      = 1'b0;

    unique case (state)
      CPU_OWN: begin
        // A waiting VGA request wins once it has been denied MAX_WAIT times.
        vga_gnt = vga_req && (!cpu_req || (wait_cnt >= MAX_CNT));
        cpu_gnt = cpu_req && !vga_gnt;
        if (vga_req && !vga_gnt)
          wait_cnt_nxt = (wait_cnt >= MAX_CNT) ? MAX_CNT : wait_cnt + 1'b1;
        if (cpu_done)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (tag == TAG_NONE)
          state_nxt = VGA_OWN;
      end
      VGA_OWN: begin
        vga_gnt = vga_req;
        if (restart)
          state_nxt = CPU_OWN;
      end
      default: state_nxt = CPU_OWN;
    endcase

    if (vga_gnt)
      tag_nxt = TAG_VGA;
    else if (cpu_gnt && !cpu_we)
      tag_nxt = TAG_CPU;
    else
      tag_nxt = TAG_NONE;
  end

  // NOTE: state registers use non-blocking assignments so all of them update
  // together from values sampled at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CPU_OWN;
      tag      <= TAG_NONE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      tag      <= tag_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Outside CPU_OWN the address bus parks on the VGA address.
  assign mem_addr   = (vga_gnt || (state != CPU_OWN)) ? vga_addr : cpu_addr;
  assign mem_wdata  = cpu_wdata;
  assign mem_we     = cpu_gnt && cpu_we;
  assign cpu_ready  = cpu_gnt;
  assign cpu_rvalid = (tag == TAG_CPU);
  assign vga_rvalid = (tag == TAG_VGA);
  assign cpu_rdata  = mem_rdata;
  assign vga_rdata  = mem_rdata;
  assign owner      = state;
  assign busy       = (tag != TAG_NONE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: stimulus queues expected read returns,
// a monitor pops them when rvalid appears and checks data and arrival cycle.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, cpu_done, restart, vga_req;
  logic [31:0] cpu_addr, cpu_wdata, vga_addr;
  logic        cpu_ready, cpu_rvalid, vga_rvalid, mem_we, busy;
  logic [31:0] cpu_rdata, vga_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  owner;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t cpu_q[$];
  exp_t vga_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .restart(restart), .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_0000;
  endfunction

  // Synchronous-read memory model: data appears one cycle after the address.
  always @(posedge clk) mem_rdata <= data_of(mem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares each read return against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cpu_rvalid) begin
          if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 32'd1, 32'd0);
          else begin
            e = cpu_q.pop_front();
            check("cpu_rdata", cpu_rdata, e.data);
            check("cpu_rvalid_cycle", cyc, e.due);
          end
        end else if (cpu_q.size() != 0 && cpu_q[0].due <= cyc) begin
          e = cpu_q.pop_front();
          check("cpu_rvalid_missing", 32'd0, 32'd1);
        end
        if (vga_rvalid) begin
          if (vga_q.size() == 0) check("vga_rvalid_unexpected", 32'd1, 32'd0);
          else begin
            e = vga_q.pop_front();
            check("vga_rdata", vga_rdata, e.data);
            check("vga_rvalid_cycle", cyc, e.due);
          end
        end else if (vga_q.size() != 0 && vga_q[0].due <= cyc) begin
          e = vga_q.pop_front();
          check("vga_rvalid_missing", 32'd0, 32'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic cr, input logic we, input logic [31:0] ca,
                       input logic [31:0] wd, input logic done, input logic rs,
                       input logic vr, input logic [31:0] va);
    @(negedge clk);
    cpu_req = cr; cpu_we = we; cpu_addr = ca; cpu_wdata = wd;
    cpu_done = done; restart = rs; vga_req = vr; vga_addr = va;
    #1;
  endtask

  task automatic push_cpu(input logic [31:0] a);
    cpu_q.push_back('{data: data_of(a), due: cyc + 1});
  endtask

  task automatic push_vga(input logic [31:0] a);
    vga_q.push_back('{data: data_of(a), due: cyc + 1});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    cpu_done = 0; restart = 0; vga_req = 0; vga_addr = 0;
    #12;
    check("rst_owner", owner, 2'b00);
    check("rst_busy", busy, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_vga_rvalid", vga_rvalid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // CPU reads 0x10 for three cycles, no VGA traffic.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
      check("t1_cpu_ready", cpu_ready, 1);
      check("t1_mem_addr", mem_addr, 32'h10);
      check("t1_mem_we", mem_we, 0);
      push_cpu(32'h10);
    end
    idle(2);

    // Contention: CPU wins 4 cycles, VGA wins the 5th, CPU again on the 6th.
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 32'h30 + i, 0, 0, 0, 1, 32'h100);
      check("t2_cpu_ready", cpu_ready, (i == 4) ? 0 : 1);
      check("t2_mem_addr", mem_addr, (i == 4) ? 32'h100 : 32'h30 + i);
      if (i == 4) push_vga(32'h100);
      else push_cpu(32'h30 + i);
    end
    idle(2);

    // Final write coincides with cpu_done; DRAIN then VGA_OWN block the CPU.
    drive(1, 1, 32'h20, 32'hAB, 1, 0, 0, 32'h300);
    check("t3_mem_we", mem_we, 1);
    check("t3_mem_addr", mem_addr, 32'h20);
    check("t3_mem_wdata", mem_wdata, 32'hAB);
    check("t3_owner_cpu", owner, 2'b00);
    drive(1, 1, 32'h24, 32'hCD, 1, 0, 0, 32'h300);
    check("t3_owner_drain", owner, 2'b01);
    check("t3_drain_we", mem_we, 0);
    check("t3_drain_ready", cpu_ready, 0);
    check("t3_drain_addr", mem_addr, 32'h300);
    drive(1, 1, 32'h28, 32'hEF, 0, 0, 0, 32'h300);
    check("t3_owner_vga", owner, 2'b10);
    check("t3_vga_we", mem_we, 0);
    check("t3_vga_ready", cpu_ready, 0);

    // VGA streams addresses 0..7 while the CPU keeps trying to write.
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 32'h28, 32'hEF, 0, 0, 1, i);
      check("t4_mem_addr", mem_addr, i);
      check("t4_mem_we", mem_we, 0);
      push_vga(i);
    end

    // restart with a VGA read issued in the same cycle: it still returns.
    drive(0, 0, 0, 0, 0, 1, 1, 32'h8);
    check("t5_owner_pre", owner, 2'b10);
    push_vga(32'h8);
    // wait_cnt cleared: CPU wins 4 cycles before VGA gets in.
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 32'h40 + i, 0, 0, 0, 1, 32'h200);
      if (i == 0) check("t5_owner_cpu", owner, 2'b00);
      check("t5_cpu_ready", cpu_ready, (i == 4) ? 0 : 1);
      if (i == 4) push_vga(32'h200);
      else push_cpu(32'h40 + i);
    end
    idle(2);

    // CPU read in the cpu_done cycle keeps DRAIN for two cycles.
    drive(1, 0, 32'h60, 0, 1, 0, 0, 32'h400);
    check("t7_ready", cpu_ready, 1);
    push_cpu(32'h60);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h400);
    check("t7_drain1", owner, 2'b01);
    check("t7_busy", busy, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h400);
    check("t7_drain2", owner, 2'b01);
    drive(0, 0, 0, 0, 0, 0, 0, 32'h400);
    check("t7_vga_own", owner, 2'b10);
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);
    check("t7_back_cpu", owner, 2'b00);

    // Reset right after a CPU read grant drops the pending return.
    drive(1, 0, 32'h50, 0, 0, 0, 0, 0);
    check("t6_ready", cpu_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_cpu_rvalid", cpu_rvalid, 0);
    check("t6_busy", busy, 0);
    check("t6_owner", owner, 2'b00);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    idle(3);

    check("cpu_queue_empty", cpu_q.size(), 0);
    check("vga_queue_empty", vga_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Arbitrates the single-port, synchronous-read data memory between two requesters. The CPU runs the image-equalization program and reads/writes the memory. The VGA controller fetches pixels from the same memory for display. The block replaces the plain END-driven address mux with a sequenced owner state machine, starvation-bounded sharing while the CPU runs, and tagged routing of read data. It sits between CPU, Control_VGA and DataMemory at the top level.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MAX_WAIT, 4, max consecutive cycles a pending VGA request may be denied during CPU_OWN (0 = VGA always wins)

Ports:
clk  in  1  system clock (CLOCK2_50 domain)
rst_n  in  1  asynchronous active-low reset (KEY[0])
cpu_req  in  1  CPU memory access request, level
cpu_we  in  1  CPU write enable, qualified by cpu_req
cpu_addr  in  ADDR_W  CPU address (ALU result)
cpu_wdata  in  DATA_W  CPU write data
cpu_done  in  1  CPU program finished (END), level
cpu_ready  out  1  CPU access accepted this cycle; CPU stalls when low
cpu_rvalid  out  1  cpu_rdata valid (1 cycle after an accepted CPU read)
cpu_rdata  out  DATA_W  read data to CPU
restart  in  1  single-cycle pulse: return ownership to CPU for a new image
vga_req  in  1  VGA pixel fetch request, level
vga_addr  in  ADDR_W  VGA pixel address
vga_rvalid  out  1  vga_rdata valid (1 cycle after an accepted VGA read)
vga_rdata  out  DATA_W  read data to VGA
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data (always cpu_wdata)
mem_we  out  1  memory write enable
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after address
owner  out  2  00 CPU_OWN, 01 DRAIN, 10 VGA_OWN
busy  out  1  read return pending (tag != NONE)

Behaviour:
- Reset (async, rst_n=0): state CPU_OWN, wait_cnt=0, tag=NONE; cpu_rvalid=0, vga_rvalid=0, busy=0, owner=00. cpu_ready, mem_we, mem_addr follow the combinational rules below with state CPU_OWN.
- Grant is combinational, decided in the same cycle. At most one grant per cycle.
- CPU_OWN:
  - VGA is granted if vga_req && (!cpu_req || wait_cnt>=MAX_WAIT). Otherwise the CPU is granted if cpu_req.
  - cpu_ready = cpu grant.
  - wait_cnt increments (saturating at MAX_WAIT) each cycle vga_req is high and VGA is not granted. It clears on any VGA grant or when vga_req is low.
- DRAIN:
  - Entered from CPU_OWN on the cycle after cpu_done=1 is sampled. A CPU grant in that sampling cycle still completes.
  - No grants. Stays until tag==NONE (normally exactly 1 cycle), then moves to VGA_OWN.
- VGA_OWN:
  - VGA is granted whenever vga_req is high. cpu_ready=0, CPU writes blocked.
  - restart=1 moves to CPU_OWN next cycle with wait_cnt cleared. A read already issued still returns.
- In CPU_OWN, simultaneous cpu_done and restart: cpu_done wins. restart in CPU_OWN or DRAIN is ignored.
- mem_addr = vga_addr when VGA is granted, or when state is VGA_OWN/DRAIN with no grant. Otherwise mem_addr = cpu_addr.
- mem_we = cpu grant && cpu_we. It is never asserted in DRAIN or VGA_OWN.
- Read tag register: tag <= VGA on a VGA grant, CPU on a CPU read grant, otherwise NONE. CPU writes produce no tag.
- cpu_rvalid = (tag==CPU) and vga_rvalid = (tag==VGA), both registered. cpu_rdata and vga_rdata pass mem_rdata through. Read latency is exactly 1 cycle from grant.
- Reset mid-access: any pending return is dropped (no rvalid), and the block restarts in CPU_OWN.

Test Plan:
- After reset, cpu_req=1 read addr 0x10 for 3 cycles, vga_req=0 -> cpu_ready=1 each cycle; mem_addr=0x10; cpu_rvalid=1 cycles 2-4 with mem_rdata.
- CPU_OWN, cpu_req and vga_req both held high, MAX_WAIT=4 -> CPU granted 4 cycles; VGA granted on cycle 5 (cpu_ready=0, vga_rvalid=1 on cycle 6); CPU granted again on cycle 6.
- cpu_req=1, cpu_we=1, addr 0x20, data 0xAB, then cpu_done=1 -> mem_we=1 for that cycle; owner=01 for 1 cycle, then 10; later cpu_we attempts give mem_we=0, cpu_ready=0.
- VGA_OWN with vga_req streaming addrs 0..7 -> mem_addr follows vga_addr each cycle; vga_rvalid high for 8 cycles, each lagging its address by 1 cycle.
- VGA_OWN, restart pulse with a VGA read in flight -> vga_rvalid still asserted next cycle; owner=00; wait_cnt=0.
- Assert rst_n=0 one cycle after a CPU read grant -> cpu_rvalid stays 0; owner=00; busy=0 immediately.
